// File: rtl/imem_prog_loader_pkg.sv
// imem_prog_loader_pkg: shared states, default geometry and address helper for the imem loader
package imem_prog_loader_pkg;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_DEPTH       = 128;
  localparam int DEF_STRIDE      = 4;
  localparam int DEF_BASE        = 0;
  localparam int DEF_RELEASE_DLY = 2;
  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;
  function automatic logic [31:0] addr_of(input int idx, input int base = DEF_BASE,
                                          input int stride = DEF_STRIDE);
    return 32'(base + idx * stride);
  endfunction
endpackage

// File: rtl/imem_prog_loader_if.sv
// imem_prog_loader_if: control, source stream and imem write port of the program loader
interface imem_prog_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              we0;
  logic [ADDR_W-1:0] wr_addr0;
  logic [DATA_W-1:0] wr_din0;
  logic              resetpc;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    output start, len, s_valid, s_data,
    input  s_ready, we0, wr_addr0, wr_din0, resetpc, busy, done, err
  );
  modport slave (
    input  start, len, s_valid, s_data,
    output s_ready, we0, wr_addr0, wr_din0, resetpc, busy, done, err
  );
endinterface

// File: rtl/imem_prog_loader_csum.sv
// imem_load_csum: wrapping sum of the image words, compared against the trailing checksum beat
module imem_load_csum #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] cmp,
  output logic              match
);
  logic [DATA_W-1:0] sum_q;
  // accumulate accepted data words; a new load restarts from zero
  always_ff @(posedge clk)
    if (reset || clear) sum_q <= '0;
    else if (add) sum_q <= sum_q + din;
  assign match = sum_q == cmp;
endmodule

// File: rtl/imem_prog_loader.sv
// imem_prog_loader: streams a program image into imem then releases the core; IMEM_LOAD_CHECKSUM_EN adds a checksum beat
module imem_prog_loader
  import imem_prog_loader_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int BYTE_STRIDE = DEF_STRIDE,
  parameter int BASE_ADDR   = DEF_BASE,
  parameter int RELEASE_DLY = DEF_RELEASE_DLY
) (
  input logic clk,
  input logic reset,
  imem_prog_loader_if.slave bus
);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int DLY_W = $clog2(RELEASE_DLY + 2);
  if (BASE_ADDR + (DEPTH - 1) * BYTE_STRIDE >= 2 ** ADDR_W) begin : g_addr_check
    $error("imem_prog_loader: image does not fit in ADDR_W");
  end
  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, idx_q;
  logic [DLY_W-1:0]  dly_q;
  logic              we0_q, resetpc_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              beat, data_beat, last_beat, csum_bad, armed, legal, start_ok, start_bad, fire;
  assign bus.s_ready = state_q == LOAD;
  assign beat        = bus.s_valid & bus.s_ready;
  assign armed       = state_q == IDLE || state_q == RUN;
  assign legal       = bus.len != '0 && bus.len <= LEN_W'(DEPTH);
  assign start_ok    = armed & bus.start & legal;
  assign start_bad   = armed & bus.start & ~legal;
  assign fire        = state_q == RELEASE && dly_q == DLY_W'(RELEASE_DLY);
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic csum_beat, csum_ok;
  assign data_beat = beat && idx_q != len_q;
  assign csum_beat = beat && idx_q == len_q;
  assign last_beat = csum_beat & csum_ok;
  assign csum_bad  = csum_beat & ~csum_ok;
  imem_load_csum #(.DATA_W(DATA_W)) u_csum (
    .clk  (clk),
    .reset(reset),
    .clear(start_ok),
    .add  (data_beat),
    .din  (bus.s_data),
    .cmp  (bus.s_data),
    .match(csum_ok)
  );
`else
  assign data_beat = beat;
  assign last_beat = beat && idx_q == len_q - 1'b1;
  assign csum_bad  = 1'b0;
`endif
  // next-state selection: accept loads from IDLE/RUN, leave LOAD on the final beat, release after the delay
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: state_d = start_ok ? LOAD : state_q;
      LOAD:      state_d = last_beat ? RELEASE : csum_bad ? IDLE : state_q;
      RELEASE:   state_d = fire ? RUN : state_q;
      default:   state_d = IDLE;
    endcase
  end
  // state register, registered imem write port, release delay counter and status flags
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      dly_q     <= '0;
      we0_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      resetpc_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we0_q     <= data_beat;
      done_q    <= fire;
      resetpc_q <= fire | (resetpc_q & ~start_ok);
      dly_q     <= state_q == RELEASE ? dly_q + 1'b1 : '0;
      if (data_beat) begin
        addr_q <= ADDR_W'(addr_of(int'(idx_q), BASE_ADDR, BYTE_STRIDE));
        din_q  <= bus.s_data;
        idx_q  <= idx_q + 1'b1;
      end
      if (start_ok) begin
        len_q <= bus.len;
        idx_q <= '0;
        err_q <= 1'b0;
      end else if (start_bad || csum_bad) begin
        err_q <= 1'b1;
      end
    end
  assign bus.we0      = we0_q;
  assign bus.wr_addr0 = addr_q;
  assign bus.wr_din0  = din_q;
  assign bus.resetpc  = resetpc_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = state_q == LOAD || state_q == RELEASE;
endmodule

// File: tb/tb_imem_prog_loader.sv
// tb_imem_prog_loader: table-driven load scenarios plus hand sequences for reload, reset and checksum
module tb_imem_prog_loader;
  import imem_prog_loader_pkg::*;
  localparam int LW = $clog2(DEF_DEPTH + 1);
  typedef struct {
    logic       rst;
    int         len;
    logic [7:0] vpat;
    int         per;
    int         exp_wr;
    logic       exp_err;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [DEF_ADDR_W-1:0] wa[$];
  logic [DEF_DATA_W-1:0] wd[$];
  int wc[$];
  int bc[$];
  int rise_cyc, done_cyc, done_cnt;
  logic rp_prev = 1'b0;
  logic rp_after, busy_after;
  vec_t vec[8];
  imem_prog_loader_if #(.DATA_W(DEF_DATA_W), .ADDR_W(DEF_ADDR_W), .LEN_W(LW)) bus ();
  imem_prog_loader dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // record every imem write and the resetpc/done events, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.we0) begin
      wa.push_back(bus.wr_addr0);
      wd.push_back(bus.wr_din0);
      wc.push_back(cyc);
    end
    if (bus.resetpc && !rp_prev) rise_cyc = cyc;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    rp_prev = bus.resetpc;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic clr_mon();
    wa.delete();
    wd.delete();
    wc.delete();
    bc.delete();
    rise_cyc = -1;
    done_cyc = -2;
    done_cnt = 0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic load(input int n_len, input logic [7:0] vpat, input int per,
                      input logic [31:0] base, input logic bad_sum);
    int sent;
    int n;
    logic [31:0] sum;
    n = n_len;
    sum = 0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    n = n_len + 1;
`endif
    bus.start = 1'b1;
    bus.len = LW'(n_len);
    tick();
    bus.start = 1'b0;
    rp_after = bus.resetpc;
    busy_after = bus.busy;
    sent = 0;
    for (int t = 0; t < 1000 && sent < n; t++) begin
      if (!bus.s_ready) break;
      bus.s_valid = vpat[3'(t % per)];
      bus.s_data = sent < n_len ? base + 32'(sent) : sum + 32'(bad_sum);
      if (bus.s_valid) begin
        bc.push_back(cyc);
        if (sent < n_len) sum += base + 32'(sent);
        sent++;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    repeat (8) tick();
  endtask
  task automatic verify(input string tag, input logic [31:0] base, input int exp_wr, input logic exp_err);
    check({tag, "_nwr"}, 64'(wa.size()), 64'(exp_wr));
    for (int k = 0; k < wa.size() && k < exp_wr; k++) begin
      check($sformatf("%s_addr%0d", tag, k), 64'(wa[k]), 64'(k * 4));
      check($sformatf("%s_data%0d", tag, k), 64'(wd[k]), 64'(base + 32'(k)));
      if (k < bc.size()) check($sformatf("%s_lat%0d", tag, k), 64'(wc[k] - bc[k]), 64'd1);
    end
    check({tag, "_err"}, 64'(bus.err), 64'(exp_err));
    check({tag, "_resetpc"}, 64'(bus.resetpc), 64'(!exp_err));
    check({tag, "_done_cnt"}, 64'(done_cnt), exp_err ? 64'd0 : 64'd1);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    if (!exp_err && wc.size() > 0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
      check({tag, "_gap"}, 64'(rise_cyc - bc[bc.size()-1]), 64'd4);
`else
      check({tag, "_gap"}, 64'(rise_cyc - wc[wc.size()-1]), 64'd3);
`endif
      check({tag, "_done_at_rise"}, 64'(done_cyc), 64'(rise_cyc));
    end
  endtask
  initial begin
    logic [31:0] base;
    vec[0] = '{1'b1, 9,   8'hFF,      1, 9,   1'b0};
    vec[1] = '{1'b1, 5,   8'b0000_0001, 3, 5, 1'b0};
    vec[2] = '{1'b1, 0,   8'hFF,      1, 0,   1'b1};
    vec[3] = '{1'b0, 129, 8'hFF,      1, 0,   1'b1};
    vec[4] = '{1'b0, 3,   8'hFF,      1, 3,   1'b0};
    vec[5] = '{1'b1, 1,   8'hFF,      1, 1,   1'b0};
    vec[6] = '{1'b1, 128, 8'hFF,      1, 128, 1'b0};
    vec[7] = '{1'b1, 4,   8'b0000_0010, 2, 4, 1'b0};
    bus.start = 1'b0;
    bus.len = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    clr_mon();
    tick();
    tick();
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_we0", 64'(bus.we0), 64'd0);
    check("rst_resetpc", 64'(bus.resetpc), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_addr", 64'(bus.wr_addr0), 64'd0);
    check("rst_din", 64'(bus.wr_din0), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i].rst) do_reset();
      clr_mon();
      base = 32'hC0DE_0000 + 32'(i << 8);
      load(vec[i].len, vec[i].vpat, vec[i].per, base, 1'b0);
      verify($sformatf("v%0d", i), base, vec[i].exp_wr, vec[i].exp_err);
    end
    clr_mon();
    load(2, 8'hFF, 1, 32'h1234_5600, 1'b0);
    check("hot_resetpc_drop", 64'(rp_after), 64'd0);
    check("hot_busy", 64'(busy_after), 64'd1);
    verify("hot", 32'h1234_5600, 2, 1'b0);
    bus.start = 1'b1;
    bus.len = '0;
    tick();
    bus.start = 1'b0;
    tick();
    check("run_bad_err", 64'(bus.err), 64'd1);
    check("run_bad_resetpc", 64'(bus.resetpc), 64'd1);
    check("run_bad_busy", 64'(bus.busy), 64'd0);
    do_reset();
    clr_mon();
    bus.start = 1'b1;
    bus.len = LW'(8);
    tick();
    bus.start = 1'b0;
    bus.s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.s_data = 32'hBEEF_0000 + 32'(k);
      tick();
    end
    bus.s_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_we0", 64'(bus.we0), 64'd0);
    check("mid_s_ready", 64'(bus.s_ready), 64'd0);
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_addr", 64'(bus.wr_addr0), 64'd0);
    check("mid_din", 64'(bus.wr_din0), 64'd0);
    reset = 1'b0;
    tick();
    check("mid_partial", 64'(wa.size()), 64'd3);
    clr_mon();
    load(8, 8'hFF, 1, 32'h0BAD_F000, 1'b0);
    verify("after_mid", 32'h0BAD_F000, 8, 1'b0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    do_reset();
    clr_mon();
    load(6, 8'hFF, 1, 32'h7700_0000, 1'b1);
    verify("csbad", 32'h7700_0000, 6, 1'b1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
